// File: rtl/word_aligner_if.sv
// Word aligner port bundle: raw words and controls in,
// aligned word and lock status out.
interface word_aligner_if #(
  parameter int DW = 64
);
  localparam int SW = $clog2(DW);

  logic [DW-1:0] din;
  logic          bypass;
  logic          align_en;
  logic          manual_en;
  logic [SW-1:0] manual_shift;
  logic [DW-1:0] dout;
  logic [SW-1:0] offset;
  logic          locked;
  logic          no_sync;
  logic [7:0]    loss_cnt;

  modport master (
    output din, bypass, align_en,
    output manual_en, manual_shift,
    input  dout, offset, locked,
    input  no_sync, loss_cnt
  );

  modport slave (
    input  din, bypass, align_en,
    input  manual_en, manual_shift,
    output dout, offset, locked,
    output no_sync, loss_cnt
  );
endinterface

// File: rtl/word_aligner.sv
// Bit-slip word aligner: windows {cur,prv} at an offset
// chosen by a sync-word search FSM, manual override or bypass.
module word_aligner #(
  parameter int            DW         = 64,
  parameter logic [DW-1:0] SYNC_WORD  = {DW/8{8'hA5}},
  parameter int            LOCK_CNT   = 4,
  parameter int            UNLOCK_CNT = 8
) (
  input  logic         clk,
  input  logic         rst,
  word_aligner_if.slave bus
);
  localparam int SW = $clog2(DW);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE, SEARCH, CONFIRM, LOCKED
  } state_t;

  state_t        state, st_n;
  logic [DW-1:0] cur, prv, dout_q;
  logic [SW-1:0] off_q, off_n, off_inc;
  logic [SW-1:0] sweep, swp_n;
  logic [MW-1:0] mcnt, mcnt_n;
  logic [EW-1:0] ecnt, ecnt_n;
  logic          lck_q, lck_n;
  logic          ns_q, ns_n;
  logic [7:0]    loss_q, loss_n;
  logic [2*DW-1:0] cat;
  logic [DW-1:0] win;
  logic          match;

  assign cat   = {cur, prv};
  assign win   = cat[off_q +: DW];
  assign match = (win == SYNC_WORD);

  assign off_inc = (off_q == SW'(DW - 1)) ?
                   '0 : off_q + SW'(1);

  // Next-state, offset and status update
  always_comb begin
    st_n   = state;
    off_n  = off_q;
    swp_n  = sweep;
    mcnt_n = mcnt;
    ecnt_n = ecnt;
    lck_n  = lck_q;
    ns_n   = ns_q;
    loss_n = loss_q;
    if (bus.manual_en) begin
      if ({1'b0, bus.manual_shift} >
          (SW + 1)'(DW - 1))
        off_n = SW'(DW - 1);
      else
        off_n = bus.manual_shift;
      st_n   = IDLE;
      lck_n  = 1'b0;
      swp_n  = '0;
      mcnt_n = '0;
      ecnt_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          lck_n = 1'b0;
          if (bus.align_en) begin
            st_n   = SEARCH;
            swp_n  = '0;
            mcnt_n = '0;
          end
        end
        SEARCH: begin
          if (!bus.align_en) begin
            st_n = IDLE;
            ns_n = 1'b0;
          end else if (match) begin
            ns_n  = 1'b0;
            swp_n = '0;
            if (LOCK_CNT == 1) begin
              st_n   = LOCKED;
              lck_n  = 1'b1;
              ecnt_n = '0;
            end else begin
              st_n   = CONFIRM;
              mcnt_n = MW'(1);
            end
          end else begin
            off_n = off_inc;
            if (sweep == SW'(DW - 1)) begin
              swp_n = '0;
              ns_n  = 1'b1;
            end else begin
              swp_n = sweep + SW'(1);
            end
          end
        end
        CONFIRM: begin
          if (!bus.align_en) begin
            st_n   = IDLE;
            mcnt_n = '0;
          end else if (match) begin
            if (mcnt == MW'(LOCK_CNT - 1)) begin
              st_n   = LOCKED;
              lck_n  = 1'b1;
              mcnt_n = '0;
              ecnt_n = '0;
            end else begin
              mcnt_n = mcnt + MW'(1);
            end
          end else begin
            st_n   = SEARCH;
            off_n  = off_inc;
            mcnt_n = '0;
            swp_n  = '0;
          end
        end
        LOCKED: begin
          if (bus.align_en) begin
            if (match) begin
              ecnt_n = '0;
            end else if (ecnt ==
                         EW'(UNLOCK_CNT - 1)) begin
              st_n   = SEARCH;
              lck_n  = 1'b0;
              off_n  = off_inc;
              ecnt_n = '0;
              swp_n  = '0;
              if (loss_q != 8'hFF)
                loss_n = loss_q + 8'd1;
            end else begin
              ecnt_n = ecnt + EW'(1);
            end
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  // Word buffers, aligned output and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cur    <= '0;
      prv    <= '0;
      dout_q <= '0;
      off_q  <= '0;
      sweep  <= '0;
      mcnt   <= '0;
      ecnt   <= '0;
      lck_q  <= 1'b0;
      ns_q   <= 1'b0;
      loss_q <= '0;
    end else begin
      state  <= st_n;
      cur    <= bus.din;
      prv    <= cur;
      dout_q <= bus.bypass ? prv : win;
      off_q  <= off_n;
      sweep  <= swp_n;
      mcnt   <= mcnt_n;
      ecnt   <= ecnt_n;
      lck_q  <= lck_n;
      ns_q   <= ns_n;
      loss_q <= loss_n;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.offset   = off_q;
  assign bus.locked   = lck_q;
  assign bus.no_sync  = ns_q;
  assign bus.loss_cnt = loss_q;
endmodule

// File: tb/tb_word_aligner.sv
// Testbench for word_aligner: manual vector table plus
// hand sequences for lock, loss, no-sync, reset, bypass.
module tb_word_aligner;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  word_aligner_if #(.DW(DW)) bus ();

  word_aligner #(.DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] exp;
    bit            chk;
  } sb_t;

  typedef struct {
    logic [5:0] shift;
    bit         byp;
    logic [5:0] exp_off;
  } vec_t;

  sb_t           sbq[$];
  logic [DW-1:0] hist = '0;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sync_w;
  logic [DW-1:0] skew_w;
  logic [DW-1:0] bad_w;

  task automatic check(input string name,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  // drive one word; queue expected dout for next edge
  task automatic step(input logic [DW-1:0] d,
                      input bit chk,
                      input int off);
    logic [2*DW-1:0] c;
    sb_t e;
    bus.din = d;
    c = {d, hist};
    e.exp = c[off +: DW];
    e.chk = chk;
    sbq.push_back(e);
    hist = d;
    @(posedge clk);
    #1;
    if (sbq.size() > 1) begin
      e = sbq.pop_front();
      if (e.chk) check("sb_dout", bus.dout, e.exp);
    end
  endtask

  initial begin
    vec_t vt[6];
    int   t13, tl, tdrop, tns;
    bit   dropped, saw63, wrapped, anylock;

    vt[0] = '{6'd8,  1'b0, 6'd8};
    vt[1] = '{6'd0,  1'b0, 6'd0};
    vt[2] = '{6'd63, 1'b0, 6'd63};
    vt[3] = '{6'd1,  1'b0, 6'd1};
    vt[4] = '{6'd8,  1'b1, 6'd8};
    vt[5] = '{6'd31, 1'b0, 6'd31};

    sync_w = {DW/8{8'hA5}};
    skew_w = (sync_w << 13) | (sync_w >> (DW - 13));
    bad_w  = skew_w ^ (64'h1 << 63);

    rst = 1'b1;
    bus.din = '0;
    bus.bypass = 1'b0;
    bus.align_en = 1'b0;
    bus.manual_en = 1'b0;
    bus.manual_shift = '0;

    // reset with random data
    for (int i = 0; i < 3; i++) step(rnd(), 0, 0);
    check("rst_dout", bus.dout, '0);
    check("rst_offset", DW'(bus.offset), '0);
    check("rst_locked", DW'(bus.locked), '0);
    check("rst_loss", DW'(bus.loss_cnt), '0);
    check("rst_nosync", DW'(bus.no_sync), '0);
    rst = 1'b0;

    // no sync: all-zero stream sweeps all offsets
    step('0, 0, 0);
    step('0, 0, 0);
    bus.align_en = 1'b1;
    tns = -1; saw63 = 0; wrapped = 0; anylock = 0;
    for (int i = 1; i <= DW + 2; i++) begin
      step('0, 0, 0);
      if (bus.offset == 6'd63) saw63 = 1;
      else if (saw63 && bus.offset == 6'd0)
        wrapped = 1;
      if (bus.locked) anylock = 1;
      if (tns < 0 && bus.no_sync) tns = i;
    end
    check("nosync_flag", DW'(bus.no_sync), 1);
    check("nosync_edge", DW'(tns), DW'(DW + 1));
    check("nosync_wrap", DW'(wrapped), 1);
    check("nosync_unlocked", DW'(anylock), 0);
    bus.align_en = 1'b0;
    step('0, 0, 0);
    check("nosync_clear", DW'(bus.no_sync), 0);

    // manual offset table
    bus.manual_en = 1'b1;
    foreach (vt[v]) begin
      bus.manual_shift = vt[v].shift;
      bus.bypass = vt[v].byp;
      sbq.delete();
      step(rnd(), 0, 0);
      step(rnd(), 0, 0);
      for (int i = 0; i < 6; i++)
        step(rnd(), 1,
             vt[v].byp ? 0 : int'(vt[v].exp_off));
      check("man_offset", DW'(bus.offset),
            DW'(vt[v].exp_off));
      check("man_locked", DW'(bus.locked), 0);
    end
    bus.bypass = 1'b0;

    // auto lock, search starting from offset 8
    bus.manual_shift = 6'd8;
    for (int i = 0; i < 3; i++) step(skew_w, 0, 0);
    bus.manual_en = 1'b0;
    bus.align_en = 1'b1;
    t13 = -1; tl = -1;
    for (int i = 0; i < 40; i++) begin
      step(skew_w, 0, 0);
      if (t13 < 0 && bus.offset == 6'd13) t13 = i;
      if (bus.locked) begin
        tl = i;
        break;
      end
    end
    check("lock_seen", DW'(tl >= 0), 1);
    check("lock_offset", DW'(bus.offset), 13);
    check("lock_latency", DW'(tl - t13), 4);
    sbq.delete();
    step(skew_w, 0, 0);
    for (int i = 0; i < 4; i++) step(skew_w, 1, 13);
    check("lock_dout", bus.dout, sync_w);

    // 7 bad words then good: lock held
    dropped = 0;
    for (int i = 0; i < 7; i++) begin
      step(bad_w, 0, 0);
      if (!bus.locked) dropped = 1;
    end
    for (int i = 0; i < 12; i++) begin
      step(skew_w, 0, 0);
      if (!bus.locked) dropped = 1;
    end
    check("seven_bad_held", DW'(dropped), 0);
    check("seven_bad_loss", DW'(bus.loss_cnt), 0);

    // 8 bad words: lock lost
    tdrop = -1;
    for (int i = 0; i < 14; i++) begin
      step((i < 8) ? bad_w : skew_w, 0, 0);
      if (tdrop < 0 && !bus.locked) begin
        tdrop = i;
        check("drop_offset", DW'(bus.offset), 14);
        check("drop_loss", DW'(bus.loss_cnt), 1);
      end
      if (i == tdrop + 1 && tdrop >= 0)
        check("drop_search", DW'(bus.offset), 15);
    end
    check("drop_edge", DW'(tdrop), 9);

    // reset mid-CONFIRM
    bus.align_en = 1'b0;
    bus.manual_en = 1'b1;
    bus.manual_shift = 6'd13;
    for (int i = 0; i < 3; i++) step(skew_w, 0, 0);
    bus.manual_en = 1'b0;
    bus.align_en = 1'b1;
    for (int i = 0; i < 3; i++) step(skew_w, 0, 0);
    rst = 1'b1;
    step(skew_w, 0, 0);
    check("mrst_dout", bus.dout, '0);
    check("mrst_offset", DW'(bus.offset), 0);
    check("mrst_locked", DW'(bus.locked), 0);
    check("mrst_loss", DW'(bus.loss_cnt), 0);
    check("mrst_nosync", DW'(bus.no_sync), 0);
    rst = 1'b0;
    bus.align_en = 1'b0;
    for (int i = 0; i < 3; i++) step(skew_w, 0, 0);
    check("mrst_idle_off", DW'(bus.offset), 0);
    check("mrst_idle_lck", DW'(bus.locked), 0);
    bus.align_en = 1'b1;
    tl = -1;
    for (int i = 0; i < 40; i++) begin
      step(skew_w, 0, 0);
      if (bus.locked) begin
        tl = i;
        break;
      end
    end
    check("relock_seen", DW'(tl >= 0), 1);
    check("relock_offset", DW'(bus.offset), 5);

    // bypass while locked in payload phase
    bus.align_en = 1'b0;
    bus.bypass = 1'b1;
    sbq.delete();
    step(rnd(), 0, 0);
    dropped = 0;
    for (int i = 0; i < 8; i++) begin
      step(rnd(), 1, 0);
      if (!bus.locked) dropped = 1;
    end
    check("byp_locked", DW'(dropped), 0);
    check("byp_offset", DW'(bus.offset), 5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
